// File: rtl/cmd_registry.sv
// Command registry: queues complete burst commands from the host and hands them to the
// master scheduler one per request, discarding any whose start time is already too close.
module cmd_registry #(
  parameter int          DEPTH = 16,
  parameter logic [63:0] GUARD = 64'd48
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     HOST_WR,
  input  logic [47:0]              IN_DDS_freq,
  input  logic [47:0]              IN_DDS_delta_freq,
  input  logic [31:0]              IN_DDS_delta_rate,
  input  logic [63:0]              IN_TIME_START,
  input  logic [15:0]              IN_N_impuls,
  input  logic [1:0]               IN_TYPE_impulse,
  input  logic [31:0]              IN_Interval_Ti,
  input  logic [31:0]              IN_Interval_Tp,
  input  logic [31:0]              IN_Tblank1,
  input  logic [31:0]              IN_Tblank2,
  input  logic                     FLUSH,
  input  logic [63:0]              TIME,
  input  logic                     REQ_COMMAND,
  output logic                     WR_DATA,
  output logic [47:0]              MEM_DDS_freq,
  output logic [47:0]              MEM_DDS_delta_freq,
  output logic [31:0]              MEM_DDS_delta_rate,
  output logic [63:0]              MEM_TIME_START,
  output logic [15:0]              MEM_N_impuls,
  output logic [1:0]               MEM_TYPE_impulse,
  output logic [31:0]              MEM_Interval_Ti,
  output logic [31:0]              MEM_Interval_Tp,
  output logic [31:0]              MEM_Tblank1,
  output logic [31:0]              MEM_Tblank2,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     OVERFLOW,
  output logic [15:0]              STALE_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] dfreq;
    logic [31:0] drate;
    logic [63:0] tstart;
    logic [15:0] n;
    logic [1:0]  typ;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  localparam cmd_t OUT_RST = '{freq: {48{1'b1}}, dfreq: {48{1'b1}}, drate: {32{1'b1}},
                               tstart: {64{1'b1}}, n: {16{1'b1}}, typ: 2'b00,
                               ti: {32{1'b1}}, tp: {32{1'b1}}, tb1: {32{1'b1}}, tb2: {32{1'b1}}};

  cmd_t            mem_q [DEPTH];
  cmd_t            in_s;
  cmd_t            stage_q, stage_d;
  cmd_t            out_q, out_d;
  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            req_q, rise_q, rise_d;
  logic [15:0]     stale_q, stale_d;
  logic            full_s, empty_s, push_s, pop_s, stale_s, wr_data_s;

  assign in_s = '{freq: IN_DDS_freq, dfreq: IN_DDS_delta_freq, drate: IN_DDS_delta_rate,
                  tstart: IN_TIME_START, n: IN_N_impuls, typ: IN_TYPE_impulse,
                  ti: IN_Interval_Ti, tp: IN_Interval_Tp, tb1: IN_Tblank1, tb2: IN_Tblank2};

  // FULL is taken from the registered level, so a push into a full queue drops even if a pop shares the edge
  assign full_s  = (level_q == LW'(DEPTH));
  assign empty_s = (level_q == {LW{1'b0}});
  assign push_s  = HOST_WR && !full_s && !FLUSH;
  assign pop_s   = (state_q == S_READ) && !empty_s && !FLUSH;
  // 65-bit compare so TIME near the top of its range cannot wrap past a start time
  assign stale_s = ({1'b0, stage_q.tstart} <= ({1'b0, TIME} + {1'b0, GUARD}));

  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_s;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (FLUSH) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {LW{1'b0}};
      ovf_d    = 1'b0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else        rd_ptr_d = rd_ptr_q;
      if (HOST_WR && full_s) ovf_d = 1'b1;
      else                   ovf_d = ovf_q;
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    rise_d  = REQ_COMMAND && !req_q && (state_q == S_WAIT) && !FLUSH;
    stage_d = stage_q;
    out_d   = out_q;
    stale_d = stale_q;
    if (pop_s) stage_d = mem_q[rd_ptr_q];
    else       stage_d = stage_q;
    if ((state_q == S_CHECK) && !FLUSH) begin
      if (!stale_s)                    out_d   = stage_q;
      else if (stale_q != 16'hFFFF)    stale_d = stale_q + 16'd1;
      else                             stale_d = stale_q;
    end else begin
      out_d = out_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = empty_s ? S_IDLE : S_READ;
        S_READ:  state_d = S_CHECK;
        S_CHECK: state_d = stale_s ? (empty_s ? S_IDLE : S_READ) : S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT:  state_d = rise_q ? (empty_s ? S_IDLE : S_READ) : S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_data_s = (state_q == S_ISSUE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      ovf_q    <= 1'b0;
      req_q    <= 1'b0;
      rise_q   <= 1'b0;
      stale_q  <= 16'd0;
      stage_q  <= '0;
      out_q    <= OUT_RST;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      req_q    <= REQ_COMMAND;
      rise_q   <= rise_d;
      stale_q  <= stale_d;
      stage_q  <= stage_d;
      out_q    <= out_d;
    end
  end

  assign WR_DATA            = wr_data_s;
  assign MEM_DDS_freq       = out_q.freq;
  assign MEM_DDS_delta_freq = out_q.dfreq;
  assign MEM_DDS_delta_rate = out_q.drate;
  assign MEM_TIME_START     = out_q.tstart;
  assign MEM_N_impuls       = out_q.n;
  assign MEM_TYPE_impulse   = out_q.typ;
  assign MEM_Interval_Ti    = out_q.ti;
  assign MEM_Interval_Tp    = out_q.tp;
  assign MEM_Tblank1        = out_q.tb1;
  assign MEM_Tblank2        = out_q.tb2;
  assign LEVEL              = level_q;
  assign FULL               = full_s;
  assign EMPTY              = empty_s;
  assign OVERFLOW           = ovf_q;
  assign STALE_CNT          = stale_q;

endmodule

// File: tb/tb_cmd_registry.sv
// Scoreboard bench for cmd_registry: accepted, non-stale pushes are queued as expected
// issues and compared against MEM_* whenever WR_DATA strobes.
module tb_cmd_registry;

  localparam int          DEPTH = 16;
  localparam logic [63:0] GUARD = 64'd48;
  localparam logic [63:0] T0    = 64'h0000_0010_0000_0000;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] dfreq;
    logic [31:0] drate;
    logic [63:0] tstart;
    logic [15:0] n;
    logic [1:0]  typ;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } cmd_t;

  logic        CLK = 1'b0;
  logic        RESET, HOST_WR, FLUSH, REQ_COMMAND;
  logic [63:0] TIME;
  cmd_t        in_cmd;
  logic        WR_DATA, FULL, EMPTY, OVERFLOW;
  logic [47:0] MEM_DDS_freq, MEM_DDS_delta_freq;
  logic [31:0] MEM_DDS_delta_rate, MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2;
  logic [63:0] MEM_TIME_START;
  logic [15:0] MEM_N_impuls, STALE_CNT;
  logic [1:0]  MEM_TYPE_impulse;
  logic [4:0]  LEVEL;
  cmd_t        mem_vec;

  int   n_total = 0;
  int   n_bad = 0;
  int   n_issued = 0;
  int   mdl_stale = 0;
  int   lat, cnt0;
  cmd_t exp_q[$];
  cmd_t last_cmd;
  cmd_t mon_e;

  always #10 CLK = ~CLK;

  cmd_registry #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .CLK(CLK), .RESET(RESET), .HOST_WR(HOST_WR),
    .IN_DDS_freq(in_cmd.freq), .IN_DDS_delta_freq(in_cmd.dfreq), .IN_DDS_delta_rate(in_cmd.drate),
    .IN_TIME_START(in_cmd.tstart), .IN_N_impuls(in_cmd.n), .IN_TYPE_impulse(in_cmd.typ),
    .IN_Interval_Ti(in_cmd.ti), .IN_Interval_Tp(in_cmd.tp), .IN_Tblank1(in_cmd.tb1), .IN_Tblank2(in_cmd.tb2),
    .FLUSH(FLUSH), .TIME(TIME), .REQ_COMMAND(REQ_COMMAND), .WR_DATA(WR_DATA),
    .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
    .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START),
    .MEM_N_impuls(MEM_N_impuls), .MEM_TYPE_impulse(MEM_TYPE_impulse),
    .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
    .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2),
    .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW), .STALE_CNT(STALE_CNT)
  );

  assign mem_vec = {MEM_DDS_freq, MEM_DDS_delta_freq, MEM_DDS_delta_rate, MEM_TIME_START,
                    MEM_N_impuls, MEM_TYPE_impulse, MEM_Interval_Ti, MEM_Interval_Tp,
                    MEM_Tblank1, MEM_Tblank2};

  task automatic check_eq(input string tag, input logic [337:0] obs, input logic [337:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input int id, input logic [63:0] ts);
    cmd_t c;
    c.freq   = 48'h1234_0000_0000 + 48'(id);
    c.dfreq  = 48'h0000_0100_0000 + 48'(id * 3);
    c.drate  = 32'hA000_0000 + 32'(id * 7);
    c.tstart = ts;
    c.n      = 16'(id + 1);
    c.typ    = 2'(id & 1);
    c.ti     = 32'h100 + 32'(id);
    c.tp     = 32'h200 + 32'(id);
    c.tb1    = 32'h300 + 32'(id);
    c.tb2    = 32'h400 + 32'(id);
    return c;
  endfunction

  function automatic bit is_stale(input logic [63:0] ts);
    return ({1'b0, ts} <= ({1'b0, TIME} + {1'b0, GUARD}));
  endfunction

  // Scoreboard: every strobe must match the oldest expected command.
  always @(negedge CLK) begin
    if (!RESET && WR_DATA) begin
      n_issued++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_issue", 338'd1, 338'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("issue_cmd", mem_vec, mon_e);
        last_cmd = mon_e;
      end
    end
  end

  task automatic push_cmd(input cmd_t c, input bit drop);
    in_cmd  = c;
    HOST_WR = 1'b1;
    @(posedge CLK);
    if (!drop) begin
      if (is_stale(c.tstart)) mdl_stale++;
      else                    exp_q.push_back(c);
    end
    #1 HOST_WR = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_wr(output int n);
    n = 0;
    while (!WR_DATA && n < 30) begin
      @(negedge CLK);
      n++;
    end
    if (!WR_DATA) check_eq("wr_timeout", 338'd0, 338'd1);
  endtask

  task automatic pulse_req();
    @(negedge CLK);
    REQ_COMMAND = 1'b1;
    @(negedge CLK);
    REQ_COMMAND = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; HOST_WR = 1'b0; FLUSH = 1'b0; REQ_COMMAND = 1'b0; TIME = T0;
    in_cmd = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check_eq("rst_wr", WR_DATA, 1'b0);
    check_eq("rst_level", LEVEL, 5'd0);
    check_eq("rst_empty", EMPTY, 1'b1);
    check_eq("rst_full", FULL, 1'b0);
    check_eq("rst_ovf", OVERFLOW, 1'b0);
    check_eq("rst_stale", STALE_CNT, 16'd0);
    check_eq("rst_tstart", MEM_TIME_START, {64{1'b1}});
    check_eq("rst_freq", MEM_DDS_freq, {48{1'b1}});
    check_eq("rst_type", MEM_TYPE_impulse, 2'b00);

    // single command into an idle registry
    push_cmd(mk(1, T0 + 64'd1000), 1'b0);
    check_eq("t1_level1", LEVEL, 5'd1);
    check_eq("t1_empty", EMPTY, 1'b0);
    wait_wr(lat);
    check_eq("t1_latency", 338'(lat + 1), 338'd4);
    check_eq("t1_tstart", MEM_TIME_START, T0 + 64'd1000);
    check_eq("t1_level0", LEVEL, 5'd0);
    @(negedge CLK);
    check_eq("t1_single_pulse", WR_DATA, 1'b0);
    pulse_req();
    repeat (3) @(negedge CLK);

    // A issues on its own, B on a pulse, C on a held request, X only on a later rise
    push_cmd(mk(2, T0 + 64'd2000), 1'b0);
    push_cmd(mk(3, T0 + 64'd2000), 1'b0);
    push_cmd(mk(4, T0 + 64'd2000), 1'b0);
    push_cmd(mk(5, T0 + 64'd2000), 1'b0);
    wait_wr(lat);
    check_eq("t2_a_latency", 338'(lat + 4), 338'd4);
    repeat (5) @(negedge CLK);
    pulse_req();
    wait_wr(lat);
    check_eq("t2_b_latency", 338'(lat + 1), 338'd4);
    repeat (5) @(negedge CLK);
    REQ_COMMAND = 1'b1;
    cnt0 = n_issued;
    @(negedge CLK);
    wait_wr(lat);
    check_eq("t2_c_latency", 338'(lat + 1), 338'd4);
    repeat (12) @(negedge CLK);
    check_eq("t2_hold_no_extra", 338'(n_issued), 338'(cnt0 + 1));
    check_eq("t2_x_queued", LEVEL, 5'd1);
    REQ_COMMAND = 1'b0;
    repeat (3) @(negedge CLK);
    pulse_req();
    wait_wr(lat);
    check_eq("t2_x_latency", 338'(lat + 1), 338'd4);
    pulse_req();
    repeat (3) @(negedge CLK);

    // two stale commands (past, exactly at the guard) ahead of one just past the guard
    push_cmd(mk(6, T0 - 64'd5), 1'b0);
    push_cmd(mk(7, T0 + GUARD), 1'b0);
    push_cmd(mk(8, T0 + GUARD + 64'd1), 1'b0);
    check_eq("t3_level_pushpop", LEVEL, 5'd2);
    wait_wr(lat);
    check_eq("t3_latency", 338'(lat + 3), 338'd8);
    check_eq("t3_stale_cnt", STALE_CNT, 16'(mdl_stale));

    // fill from WAIT: 16 accepted, 17th dropped
    for (int i = 0; i < 16; i++) push_cmd(mk(100 + i, T0 + 64'd5000), 1'b0);
    push_cmd(mk(116, T0 + 64'd5000), 1'b1);
    check_eq("t4_full", FULL, 1'b1);
    check_eq("t4_level16", LEVEL, 5'd16);
    check_eq("t4_ovf", OVERFLOW, 1'b1);
    check_eq("t4_not_empty", EMPTY, 1'b0);
    pulse_req();
    wait_wr(lat);
    check_eq("t4_latency", 338'(lat + 1), 338'd4);
    check_eq("t4_level15", LEVEL, 5'd15);
    for (int i = 0; i < 10; i++) begin
      pulse_req();
      wait_wr(lat);
    end
    check_eq("t4_level5", LEVEL, 5'd5);
    check_eq("t4_ovf_sticky", OVERFLOW, 1'b1);

    // flush while the next candidate sits in CHECK
    @(negedge CLK);
    REQ_COMMAND = 1'b1;
    @(negedge CLK);
    REQ_COMMAND = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    FLUSH = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    FLUSH = 1'b0;
    cnt0 = n_issued;
    check_eq("t5_level", LEVEL, 5'd0);
    check_eq("t5_empty", EMPTY, 1'b1);
    check_eq("t5_full", FULL, 1'b0);
    check_eq("t5_ovf", OVERFLOW, 1'b0);
    check_eq("t5_mem_hold", mem_vec, last_cmd);
    repeat (8) @(negedge CLK);
    check_eq("t5_no_issue", 338'(n_issued), 338'(cnt0));

    // starved registry: a rise with nothing queued returns to IDLE
    push_cmd(mk(20, T0 + 64'd3000), 1'b0);
    wait_wr(lat);
    check_eq("t6_e_latency", 338'(lat + 1), 338'd4);
    pulse_req();
    repeat (20) @(negedge CLK);
    push_cmd(mk(21, T0 + 64'd3000), 1'b0);
    wait_wr(lat);
    check_eq("t6_d_latency", 338'(lat + 1), 338'd4);

    // reset while a command is in CHECK
    push_cmd(mk(22, T0 + 64'd3000), 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    exp_q.delete();
    mdl_stale = 0;
    cnt0 = n_issued;
    @(negedge CLK);
    RESET = 1'b0;
    check_eq("t7_wr", WR_DATA, 1'b0);
    check_eq("t7_level", LEVEL, 5'd0);
    check_eq("t7_empty", EMPTY, 1'b1);
    check_eq("t7_stale", STALE_CNT, 16'(mdl_stale));
    check_eq("t7_tstart", MEM_TIME_START, {64{1'b1}});
    check_eq("t7_type", MEM_TYPE_impulse, 2'b00);
    repeat (8) @(negedge CLK);
    check_eq("t7_no_issue", 338'(n_issued), 338'(cnt0));

    check_eq("sb_drained", 338'(exp_q.size()), 338'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
